store_buffer: RTL
=================

# store_buffer

Write buffer between the single-cycle CPU's data path and a slower data memory. It queues CPU stores in a FIFO so the CPU continues without waiting for memory, and drains them to memory over a valid/ready handshake. Loads read memory directly; with forwarding compiled in, loads are served from the youngest matching pending store. It sits downstream of the CPU's ALU address / regfile B-port outputs and upstream of the data memory.

## Interface
- DEPTH, 4, number of store entries (power of two, ≥2)
- AW, 32, address width
- DW, 32, data width
- clk  in  1  clock, all state updates on rising edge
- rstN  in  1  asynchronous, active-low reset
- cpuWe  in  1  store request this cycle
- cpuRe  in  1  load request this cycle
- cpuAddr  in  AW  byte address of load/store (word-aligned; bits [1:0] ignored)
- cpuWData  in  DW  store data
- cpuRData  out  DW  load data, combinational
- stall  out  1  CPU must hold the current instruction (PC and regfile write suppressed by CPU)
- memValid  out  1  head store presented to memory
- memReady  in  1  memory accepts the head store this cycle
- memAddr  out  AW  head store address
- memWData  out  DW  head store data
- memRAddr  out  AW  load address to memory asynchronous read port (= cpuAddr)
- memRData  in  DW  memory read data

## Operation
- Circular FIFO: head pointer, tail pointer, count (0..DEPTH, width clog2(DEPTH)+1).
- Enqueue: cpuWe && count!=DEPTH -> write {cpuAddr, cpuWData} at tail, tail++.
- Dequeue: memValid && memReady -> head++.
- Enqueue and dequeue in the same cycle: count unchanged; both pointers advance.
- Full: cpuWe && count==DEPTH -> stall=1, no enqueue; a same-cycle dequeue does not bypass (store accepted next cycle).
- memValid = (count!=0); memAddr/memWData = head entry; must be stable while memValid && !memReady.
- Address match compares addr[AW-1:2] only; entries beyond count are never matched.
- Load (cpuRe): see Configuration. cpuWe and cpuRe simultaneously is illegal (CPU never issues both); behaviour unspecified.
- Pointer wrap: DEPTH-1 -> 0; order of drain equals order of enqueue across wrap.

## Timing
- Reset (rstN=0, asynchronous): count=0, head=tail=0, memValid=0, memAddr=0, memWData=0, stall=0, entries need not clear. Reset mid-drain discards all pending stores.
- Store latency: enqueued at edge N; earliest memValid with that entry at cycle N+1 if buffer was empty.
- Drain throughput: one store per cycle while memReady=1.
- stall, cpuRData: combinational from current inputs and state; no registered outputs except FIFO state.

## Configuration
- STORE_FWD_EN defined: on cpuRe, if any pending entry matches, cpuRData = data of youngest matching entry (closest to tail); else memRData. stall never asserted for loads.
- STORE_FWD_EN undefined: cpuRData = memRData always; cpuRe with any matching pending entry -> stall=1 until no matching entry remains (drained).

## Structure
- Package sb_pkg: DEPTH default, pointer/count widths, WORD_LSB=2 constant, entry struct {addr, data}.
- One sub-module: sb_match — DEPTH-wide compare plus youngest-first priority select (returns hit and index), relative to head/count.
- FIFO storage, pointers and handshake in store_buffer.

## Test plan
- Reset: drive rstN=0 mid-drain with count=3 -> memValid=0, count=0 immediately; no further memory writes after release.
- Fill: memReady=0, 5 stores to 0x10,0x14,0x18,0x1C,0x20 -> first four accepted, fifth asserts stall until memReady=1 for one cycle, accepted next edge.
- Drain order/wrap: 6 stores interleaved with memReady toggling -> memory observes addresses/data in exact issue order, memAddr stable while stalled by memReady=0.
- Simultaneous: count=2, store plus memReady=1 same cycle -> count stays 2, correct head/tail.
- Forwarding (STORE_FWD_EN): stores 0xAA then 0xBB to 0x40, memReady=0, load 0x40 -> cpuRData=0xBB, stall=0; load 0x42 also -> 0xBB; load 0x44 -> memRData.
- No forwarding: same sequence -> stall=1 until both 0x40 entries drain, then cpuRData=memRData.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared sizing constants and entry type for the store buffer.
// Widths here are the defaults; modules re-derive widths from their own parameters.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;
    localparam int WORD_LSB = 2;
    localparam int PTR_W    = $clog2(SB_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Word-address compare over the live FIFO window, walking oldest to youngest
// so the last hit found is the youngest matching store.
module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int WAW   = SB_AW - WORD_LSB
) (
    input  logic [DEPTH-1:0][WAW-1:0]   waddr_i,
    input  logic [WAW-1:0]              qaddr_i,
    input  logic [$clog2(DEPTH)-1:0]    head_i,
    input  logic [$clog2(DEPTH):0]      count_i,
    output logic                        hit_o,
    output logic [$clog2(DEPTH)-1:0]    idx_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] pos;

    always_comb begin
        hit_o = 1'b0;
        idx_o = head_i;
        pos   = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head_i + PW'(k);
            if ((CW'(k) < count_i) && (waddr_i[pos] == qaddr_i)) begin
                hit_o = 1'b1;
                idx_o = pos;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// CPU-to-memory store FIFO with valid/ready drain.
// Define STORE_FWD_EN to forward loads from pending stores instead of stalling.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          cpuWe,
    input  logic          cpuRe,
    input  logic [AW-1:0] cpuAddr,
    input  logic [DW-1:0] cpuWData,
    output logic [DW-1:0] cpuRData,
    output logic          stall,
    output logic          memValid,
    input  logic          memReady,
    output logic [AW-1:0] memAddr,
    output logic [DW-1:0] memWData,
    output logic [AW-1:0] memRAddr,
    input  logic [DW-1:0] memRData
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WAW = AW - WORD_LSB;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0]      ent_q;
    logic   [PW-1:0]         head_q, head_d;
    logic   [PW-1:0]         tail_q, tail_d;
    logic   [CW-1:0]         count_q, count_d;
    logic                    full;
    logic                    do_enq;
    logic                    do_deq;
    logic [DEPTH-1:0][WAW-1:0] waddr;
    logic                    hit;
    logic [PW-1:0]           hit_idx;

    assign full     = (count_q == CW'(DEPTH));
    assign memValid = (count_q != '0);
    // A full buffer never takes a store even if the head drains this cycle.
    assign do_enq   = cpuWe && !full;
    assign do_deq   = memValid && memReady;
    assign memAddr  = memValid ? ent_q[head_q].addr : '0;
    assign memWData = memValid ? ent_q[head_q].data : '0;
    assign memRAddr = cpuAddr;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            waddr[i] = ent_q[i].addr[AW-1:WORD_LSB];
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW)
    ) u_match (
        .waddr_i (waddr),
        .qaddr_i (cpuAddr[AW-1:WORD_LSB]),
        .head_i  (head_q),
        .count_i (count_q),
        .hit_o   (hit),
        .idx_o   (hit_idx)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_deq) begin
            head_d = head_q + PW'(1);
        end
        if (do_enq) begin
            tail_d = tail_q + PW'(1);
        end
        unique case ({do_enq, do_deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            ent_q[tail_q] <= '{addr: cpuAddr, data: cpuWData};
        end
    end

`ifdef STORE_FWD_EN
    assign cpuRData = (cpuRe && hit) ? ent_q[hit_idx].data : memRData;
    assign stall    = cpuWe && full;
`else
    logic unused_idx;
    assign unused_idx = ^hit_idx;
    // Hold a load until every older store to its word has reached memory.
    assign cpuRData   = memRData;
    assign stall      = (cpuWe && full) || (cpuRe && hit);
`endif

endmodule
